// File: rtl/pipeline_perf_monitor.sv
// rtl/pipeline_perf_monitor.sv - run-control FSM with saturating cycle/instret/event counters
// Optional cycle-limit watchdog is built in when PERF_WATCHDOG_EN is defined.
module pipeline_perf_monitor #(
  parameter int               CNT_W        = 32,
  parameter int               NUM_EVT      = 4,
  parameter int               DRAIN_CYCLES = 4,
  parameter logic [31:0]      HALT_INSTR   = 32'h0000_0000,
  parameter int               WDOG_LIMIT   = 10000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic                     retire_valid,
  input  logic [NUM_EVT-1:0]       evt_in,
  output logic                     running,
  output logic                     end_program,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instret_count,
  output logic [NUM_EVT*CNT_W-1:0] evt_count,
  output logic [NUM_EVT+1:0]       overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int                DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]     DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
  localparam logic [63:0]       WDOG_LAST  = 64'(WDOG_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam int                NCNT       = NUM_EVT + 2;

  state_t            state, state_n;
  logic [DW-1:0]     drain_cnt;
  logic [CNT_W-1:0]  cnt [NCNT];
  logic [NCNT-1:0]   inc;
  logic              counting, halt, wdog_en, wdog_hit, timeout_r;

`ifdef PERF_WATCHDOG_EN
  assign wdog_en = 1'b1;
`else
  assign wdog_en = 1'b0;
`endif

  assign counting = (state == RUN) || (state == DRAIN);
  assign halt     = if_valid && (if_instr == HALT_INSTR);
  assign wdog_hit = wdog_en && counting && (64'(cnt[0]) == WDOG_LAST);
  // Counter index 0 is cycles (always increments), 1 is instret, 2.. are events.
  assign inc      = {evt_in, retire_valid, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (clear) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_n = RUN;
        RUN:     if (wdog_hit) state_n = DONE;
                 else if (halt) state_n = DRAIN;
        DRAIN:   if (wdog_hit || drain_cnt == '0) state_n = DONE;
        default: state_n = DONE;
      endcase
    end
  end

  always_comb begin
    running     = counting;
    end_program = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
    end else if (clear) begin
      drain_cnt <= '0;
    end else if (state == RUN && halt && !wdog_hit) begin
      drain_cnt <= DRAIN_INIT;
    end else if (state == DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      overflow <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      overflow <= '0;
    end else if (counting) begin
      for (int i = 0; i < NCNT; i++) begin
        if (inc[i]) begin
          if (&cnt[i]) overflow[i] <= 1'b1;
          else         cnt[i]      <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        timeout_r <= 1'b0;
    else if (clear)    timeout_r <= 1'b0;
    else if (wdog_hit) timeout_r <= 1'b1;
  end

  assign timeout       = timeout_r;
  assign cycle_count   = cnt[0];
  assign instret_count = cnt[1];

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
    assign evt_count[g*CNT_W +: CNT_W] = cnt[2+g];
  end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb/tb_pipeline_perf_monitor.sv - scoreboard bench for pipeline_perf_monitor
// Main instance uses WDOG_LIMIT=50; a CNT_W=4 instance exercises saturation.
module tb_pipeline_perf_monitor;

  typedef struct {
    string        name;
    bit           sel;
    logic [31:0]  cyc;
    logic [31:0]  ret;
    logic [127:0] evt;
    logic [5:0]   ovf;
    logic         to;
    logic         ep;
    logic         run;
  } exp_t;

  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, start = 1'b0, sat_start = 1'b0;
  logic if_valid = 1'b0, retire_valid = 1'b0;
  logic [31:0] if_instr = 32'h0000_0013;
  logic [3:0]  evt_in = 4'b0;

  logic         running, end_program, timeout;
  logic [31:0]  cycle_count, instret_count;
  logic [127:0] evt_count;
  logic [5:0]   overflow;

  logic         s_running, s_end_program, s_timeout;
  logic [3:0]   s_cycle_count, s_instret_count;
  logic [15:0]  s_evt_count;
  logic [5:0]   s_overflow;

  int   total = 0, bad = 0;
  exp_t done_q[$];
  exp_t snap_q[$];
  event snap_ev;

  always #5 clk = ~clk;

  pipeline_perf_monitor #(.WDOG_LIMIT(50)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .if_valid(if_valid), .if_instr(if_instr), .retire_valid(retire_valid), .evt_in(evt_in),
    .running(running), .end_program(end_program), .timeout(timeout),
    .cycle_count(cycle_count), .instret_count(instret_count),
    .evt_count(evt_count), .overflow(overflow)
  );

  pipeline_perf_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .clear(1'b0), .start(sat_start),
    .if_valid(1'b0), .if_instr(32'h0000_0013), .retire_valid(1'b0), .evt_in(4'b0),
    .running(s_running), .end_program(s_end_program), .timeout(s_timeout),
    .cycle_count(s_cycle_count), .instret_count(s_instret_count),
    .evt_count(s_evt_count), .overflow(s_overflow)
  );

  task automatic chk(string n, logic [127:0] act, logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  task automatic cmp(exp_t e);
    if (e.sel == 1'b0) begin
      chk({e.name, ".cycle"},   128'(cycle_count),   128'(e.cyc));
      chk({e.name, ".instret"}, 128'(instret_count), 128'(e.ret));
      chk({e.name, ".evt"},     evt_count,           e.evt);
      chk({e.name, ".ovf"},     128'(overflow),      128'(e.ovf));
      chk({e.name, ".timeout"}, 128'(timeout),       128'(e.to));
      chk({e.name, ".end"},     128'(end_program),   128'(e.ep));
      chk({e.name, ".running"}, 128'(running),       128'(e.run));
    end else begin
      chk({e.name, ".cycle"},   128'(s_cycle_count),   128'(e.cyc));
      chk({e.name, ".instret"}, 128'(s_instret_count), 128'(e.ret));
      chk({e.name, ".evt"},     128'(s_evt_count),     e.evt);
      chk({e.name, ".ovf"},     128'(s_overflow),      128'(e.ovf));
      chk({e.name, ".timeout"}, 128'(s_timeout),       128'(e.to));
      chk({e.name, ".end"},     128'(s_end_program),   128'(e.ep));
      chk({e.name, ".running"}, 128'(s_running),       128'(e.run));
    end
  endtask

  function automatic exp_t mk(string n, bit sel, logic [31:0] cyc, logic [31:0] ret,
                              logic [127:0] evt, logic [5:0] ovf, logic to, logic ep, logic run);
    exp_t e;
    e.name = n; e.sel = sel; e.cyc = cyc; e.ret = ret; e.evt = evt;
    e.ovf = ovf; e.to = to; e.ep = ep; e.run = run;
    return e;
  endfunction

  task automatic snap(exp_t e);
    snap_q.push_back(e);
    ->snap_ev;
    #1;
  endtask

  task automatic nc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    nc(1);
    clear = 1'b0;
  endtask

  // Completion monitor: each rising end_program consumes one expected record.
  initial begin
    logic ep_prev;
    ep_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (end_program && !ep_prev) begin
        if (done_q.size() == 0) chk("unexpected_end", 128'(1), 128'(0));
        else                    cmp(done_q.pop_front());
      end
      ep_prev = end_program;
    end
  end

  initial begin
    forever begin
      @(snap_ev);
      while (snap_q.size() > 0) cmp(snap_q.pop_front());
    end
  end

  initial begin
    // reset state
    nc(2);
    snap(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0));
    snap(mk("reset_sat", 1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    nc(1);

    // 1: six retires, halt seven edges after start
    start = 1'b1;
    nc(1);
    start = 1'b0;
    snap(mk("t1_run", 0, 0, 0, 0, 0, 0, 0, 1));
    retire_valid = 1'b1;
    nc(6);
    retire_valid = 1'b0;
    done_q.push_back(mk("t1_done", 0, 11, 6, 0, 0, 0, 1, 0));
    if_valid = 1'b1; if_instr = 32'h0;
    nc(1);
    if_valid = 1'b0; if_instr = 32'h0000_0013;
    nc(3);
    snap(mk("t1_drain", 0, 10, 6, 0, 0, 0, 0, 1));
    nc(2);

    // 2: 4-bit counter saturation
    sat_start = 1'b1;
    nc(1);
    sat_start = 1'b0;
    nc(20);
    snap(mk("t2_sat", 1, 15, 0, 0, 6'b000001, 0, 0, 1));

    // 3: events 0 and 2 held from start through drain
    clear_pulse();
    snap(mk("t3_clear", 0, 0, 0, 0, 0, 0, 0, 0));
    evt_in = 4'b0101; start = 1'b1;
    nc(1);
    start = 1'b0;
    nc(4);
    done_q.push_back(mk("t3_done", 0, 9, 0, {64'd0, 32'd9, 32'd0, 32'd9}, 0, 0, 1, 0)
                     ) ;
    if_valid = 1'b1; if_instr = 32'h0;
    nc(1);
    if_valid = 1'b0; if_instr = 32'h0000_0013;
    nc(4);
    nc(3);
    snap(mk("t3_frozen", 0, 9, 0, {64'd0, 32'd9, 32'd0, 32'd9}, 0, 0, 1, 0));
    evt_in = 4'b0;

    // 4: clear during drain, then a normal rerun
    clear_pulse();
    start = 1'b1;
    nc(1);
    start = 1'b0;
    nc(1);
    if_valid = 1'b1; if_instr = 32'h0;
    nc(1);
    if_valid = 1'b0; if_instr = 32'h0000_0013;
    clear_pulse();
    snap(mk("t4_cleared", 0, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b1;
    nc(1);
    start = 1'b0;
    nc(2);
    done_q.push_back(mk("t4_rerun", 0, 7, 0, 0, 0, 0, 1, 0));
    if_valid = 1'b1; if_instr = 32'h0;
    nc(1);
    if_valid = 1'b0; if_instr = 32'h0000_0013;
    nc(5);

    // 5: asynchronous reset between edges mid-run
    clear_pulse();
    start = 1'b1;
    nc(1);
    start = 1'b0;
    retire_valid = 1'b1;
    nc(3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    snap(mk("t5_async", 0, 0, 0, 0, 0, 0, 0, 0));
    snap(mk("t5_async_sat", 1, 0, 0, 0, 0, 0, 0, 0));
    retire_valid = 1'b0;
    nc(2);
    reset = 1'b1;
    nc(1);

    // 6: no halt; watchdog fires at 50 only when built in
    start = 1'b1;
    nc(1);
    start = 1'b0;
`ifdef PERF_WATCHDOG_EN
    done_q.push_back(mk("t6_wdog", 0, 50, 0, 0, 0, 1, 1, 0));
    nc(49);
    snap(mk("t6_pre", 0, 49, 0, 0, 0, 0, 0, 1));
    nc(3);
    snap(mk("t6_sticky", 0, 50, 0, 0, 0, 1, 1, 0));
`else
    nc(100);
    snap(mk("t6_free", 0, 100, 0, 0, 0, 0, 0, 1));
`endif

    nc(2);
    chk("done_q_drained", 128'(done_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
